// File: rtl/seq_count_checker.sv
// Receive-side integrity checker for incrementing counter streams.
// Locks after a run of consecutive +1 steps, then counts and strobes sequence breaks.
module seq_count_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected,
  output logic [WIDTH-1:0]     last_data
);

  // Run counter only ever needs to reach LOCK_COUNT-1 before the lock transition.
  localparam int unsigned RunW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0]     DataOne = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ErrOne  = ERR_CNT_W'(1);
  localparam logic [RunW-1:0]      RunOne  = RunW'(1);
  localparam logic [RunW-1:0]      RunLast = RunW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  state_e          state;
  logic [RunW-1:0] run;
  logic            match;

  assign match = (in_data == expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      run       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
      last_data <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        last_data <= in_data;
        expected  <= in_data + DataOne;
        case (state)
          StIdle: begin
            run   <= '0;
            state <= StAcquire;
          end
          StAcquire: begin
            if (!match) begin
              run <= '0;
            end else if (run == RunLast) begin
              run    <= '0;
              locked <= 1'b1;
              state  <= StLocked;
            end else begin
              run <= run + RunOne;
            end
          end
          StLocked: begin
            if (!match) begin
              err_pulse <= 1'b1;
              locked    <= 1'b0;
              run       <= '0;
              state     <= StAcquire;
              if (err_count != '1) begin
                err_count <= err_count + ErrOne;
              end
            end
          end
          default: begin
            run    <= '0;
            locked <= 1'b0;
            state  <= StIdle;
          end
        endcase
      end
      // Clear wins over a coincident increment; the pulse is unaffected.
      if (clear) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_count_checker.sv
// Directed-vector bench for seq_count_checker: default instance plus a narrow
// error-counter instance for saturation and clear behaviour.
module tb_seq_count_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance
  logic       rst, in_valid, clear;
  logic [3:0] in_data;
  logic       locked, err_pulse;
  logic [7:0] err_count;
  logic [3:0] expected, last_data;

  seq_count_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected),
    .last_data (last_data)
  );

  // Two-bit error counter instance
  logic       rst2, in_valid2, clear2;
  logic [3:0] in_data2;
  logic       locked2, err_pulse2;
  logic [1:0] err_count2;
  logic [3:0] expected2, last_data2;

  seq_count_checker #(.ERR_CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .clear     (clear2),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .expected  (expected2),
    .last_data (last_data2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic v, input logic [3:0] d, input logic c);
    in_valid2 = v;
    in_data2  = d;
    clear2    = c;
    @(posedge clk);
    #1;
    clear2 = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) send(1'b1, 4'($urandom));
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_pulse"}, int'(err_pulse), 0);
    check_eq({tag, "_count"}, int'(err_count), 0);
    check_eq({tag, "_expected"}, int'(expected), 0);
    check_eq({tag, "_last"}, int'(last_data), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; clear2 = 1'b0;

    // Reset with random data and valid high
    do_reset(2);
    check_zero("reset");

    // Clean stream 0..15,0,1; lock after the 4th sample, no errors through wrap
    for (int i = 0; i < 18; i++) begin
      send(1'b1, 4'(i));
      check_eq("clean_locked", int'(locked), int'(i >= 3));
      check_eq("clean_pulse", int'(err_pulse), 0);
    end
    check_eq("clean_count", int'(err_count), 0);
    check_eq("clean_expected", int'(expected), 2);
    check_eq("clean_last", int'(last_data), 1);

    // Break while locked: 0..5, 9..13
    do_reset(1);
    for (int i = 0; i <= 5; i++) send(1'b1, 4'(i));
    check_eq("brk_locked_pre", int'(locked), 1);
    send(1'b1, 4'd9);
    check_eq("brk_pulse", int'(err_pulse), 1);
    check_eq("brk_count", int'(err_count), 1);
    check_eq("brk_locked_fall", int'(locked), 0);
    check_eq("brk_expected", int'(expected), 10);
    send(1'b1, 4'd10);
    check_eq("brk_pulse_once", int'(err_pulse), 0);
    send(1'b1, 4'd11);
    check_eq("brk_locked_11", int'(locked), 0);
    send(1'b1, 4'd12);
    check_eq("brk_relock", int'(locked), 1);
    send(1'b1, 4'd13);
    check_eq("brk_expected_13", int'(expected), 14);
    check_eq("brk_count_end", int'(err_count), 1);

    // Valid gaps with garbage data in between
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'(i));
      check_eq("gap_locked", int'(locked), int'(i == 3));
      for (int g = 0; g < 3; g++) begin
        send(1'b0, 4'($urandom));
        check_eq("gap_hold_locked", int'(locked), int'(i == 3));
        check_eq("gap_hold_expected", int'(expected), (i + 1) % 16);
        check_eq("gap_hold_last", int'(last_data), i);
        check_eq("gap_pulse", int'(err_pulse), 0);
      end
    end
    check_eq("gap_count", int'(err_count), 0);

    // Reset mid-lock with a mismatch in flight
    do_reset(1);
    for (int i = 0; i <= 7; i++) send(1'b1, 4'(i));
    check_eq("midrst_locked_pre", int'(locked), 1);
    rst = 1'b1;
    send(1'b1, 4'd3);
    rst = 1'b0;
    check_zero("midrst");
    for (int i = 4; i <= 7; i++) begin
      send(1'b1, 4'(i));
      check_eq("midrst_locked", int'(locked), int'(i == 7));
      check_eq("midrst_pulse", int'(err_pulse), 0);
    end
    check_eq("midrst_count", int'(err_count), 0);

    // Saturation and clear on the 2-bit counter instance
    send2(1'b1, 4'd0, 1'b0);
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) send2(1'b1, 4'(i), 1'b0);
    check_eq("sat_locked", int'(locked2), 1);
    for (int k = 1; k <= 5; k++) begin
      send2(1'b1, 4'd10, 1'b0);
      check_eq("sat_pulse", int'(err_pulse2), 1);
      check_eq("sat_count", int'(err_count2), (k > 3) ? 3 : k);
      check_eq("sat_unlocked", int'(locked2), 0);
      for (int j = 11; j <= 13; j++) send2(1'b1, 4'(j), 1'b0);
      check_eq("sat_relock", int'(locked2), 1);
    end
    send2(1'b1, 4'd10, 1'b1);
    check_eq("clr_pulse", int'(err_pulse2), 1);
    check_eq("clr_count", int'(err_count2), 0);
    // Back-to-back mismatch lands in ACQUIRE: no pulse, no count
    send2(1'b1, 4'd2, 1'b0);
    check_eq("b2b_pulse", int'(err_pulse2), 0);
    check_eq("b2b_count", int'(err_count2), 0);
    check_eq("b2b_expected", int'(expected2), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
